// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
//
// Sequential front end for the combinational execute-stage ALU. It accepts one
// RV32I OP / OP-IMM arithmetic request per valid/ready handshake. It decodes
// funct3/funct7[5] into the ALU's 4-bit control code and drives registered
// operands to the ALU for one full cycle. It then captures the ALU result and
// flags and returns them on a valid/ready response port.
//
// Illegal encodings bypass the ALU. They return a zeroed response with
// out_illegal set, and the ALU operand registers are left untouched.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      request handshake
//   funct3, funct7b5, is_imm instruction fields (funct7b5 = instruction bit 30)
//   rs1_val, rhs             operands (rhs = rs2 or sign-extended immediate)
//   alu_a, alu_b,
//   alu_control              registered ALU operands and control code
//   alu_result, alu_overflow,
//   alu_zero, alu_equal      combinational ALU response
//   out_valid / out_ready    response handshake
//   out_result, out_overflow,
//   out_zero, out_equal,
//   out_illegal              captured response
//   op_count                 completed responses, wraps modulo 2^16
//
// Only N = 32 is supported. The shift-amount masking assumes a 5-bit shamt.
// -----------------------------------------------------------------------------
module alu_issue_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,

   // request side
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   funct3,
   input  logic         funct7b5,
   input  logic         is_imm,
   input  logic [N-1:0] rs1_val,
   input  logic [N-1:0] rhs,

   // ALU port (initiator side)
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_control,
   input  logic [N-1:0] alu_result,
   input  logic         alu_overflow,
   input  logic         alu_zero,
   input  logic         alu_equal,

   // response side
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic         out_overflow,
   output logic         out_zero,
   output logic         out_equal,
   output logic         out_illegal,
   output logic [15:0]  op_count
);

   // ALU control encoding shared with the ALU.
   typedef enum logic [3:0] {
      CTL_AND  = 4'd1,
      CTL_OR   = 4'd2,
      CTL_XOR  = 4'd3,
      CTL_SLL  = 4'd5,
      CTL_SRL  = 4'd6,
      CTL_SRA  = 4'd7,
      CTL_ADD  = 4'd8,
      CTL_SUB  = 4'd12,
      CTL_SLT  = 4'd13,
      CTL_SLTU = 4'd15
   } alu_control_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       state;
   alu_control_t ctl_q;

   // ---------------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------------
   alu_control_t dec_ctl;
   logic         dec_illegal;
   logic         dec_shift;
   logic [N-1:0] dec_b;
   logic         r_b5;       // funct7[5] set on an R-type instruction

   assign r_b5 = funct7b5 & ~is_imm;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through
      // the case statement leaves one unassigned and no latch is inferred.
      dec_ctl     = CTL_ADD;
      dec_illegal = 1'b0;
      dec_shift   = 1'b0;

      case (funct3)
         3'b000: dec_ctl = r_b5 ? CTL_SUB : CTL_ADD;
         3'b001: begin
            dec_ctl     = CTL_SLL;
            dec_shift   = 1'b1;
            // funct7[5] must be 0 for SLL and SLLI alike.
            dec_illegal = funct7b5;
         end
         3'b010: begin
            dec_ctl     = CTL_SLT;
            dec_illegal = r_b5;
         end
         3'b011: begin
            dec_ctl     = CTL_SLTU;
            dec_illegal = r_b5;
         end
         3'b100: begin
            dec_ctl     = CTL_XOR;
            dec_illegal = r_b5;
         end
         3'b101: begin
            // Bit 30 selects arithmetic shift in both R and I forms.
            dec_ctl   = funct7b5 ? CTL_SRA : CTL_SRL;
            dec_shift = 1'b1;
         end
         3'b110: begin
            dec_ctl     = CTL_OR;
            dec_illegal = r_b5;
         end
         3'b111: begin
            dec_ctl     = CTL_AND;
            dec_illegal = r_b5;
         end
         default: begin
            dec_ctl     = CTL_ADD;
            dec_illegal = 1'b1;
         end
      endcase

      // Shifts take only shamt. This keeps immediate bit 10 (the SRAI marker,
      // which lands in rhs[10]) away from the ALU's out-of-range shift zeroing.
      dec_b = dec_shift ? {{(N-5){1'b0}}, rhs[4:0]} : rhs;
   end

   // ---------------------------------------------------------------------------
   // Control FSM with registered handshake outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then samples pre-edge values, whatever the statement order.
      if (rst) begin
         state        <= S_IDLE;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         alu_a        <= '0;
         alu_b        <= '0;
         ctl_q        <= CTL_ADD;
         out_result   <= '0;
         out_overflow <= 1'b0;
         out_zero     <= 1'b0;
         out_equal    <= 1'b0;
         out_illegal  <= 1'b0;
         op_count     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (dec_illegal) begin
                     // The ALU is not used. Its operand registers keep the
                     // previous op's values and the response is zeroed.
                     out_illegal  <= 1'b1;
                     out_result   <= '0;
                     out_overflow <= 1'b0;
                     out_zero     <= 1'b0;
                     out_equal    <= 1'b0;
                     out_valid    <= 1'b1;
                     state        <= S_DONE;
                  end else begin
                     alu_a       <= rs1_val;
                     alu_b       <= dec_b;
                     ctl_q       <= dec_ctl;
                     out_illegal <= 1'b0;
                     state       <= S_EXEC;
                  end
               end
            end

            S_EXEC: begin
               // The operands have been stable for the whole cycle, so the
               // ALU output has settled by this edge.
               out_result   <= alu_result;
               out_overflow <= alu_overflow &
                               ((ctl_q == CTL_ADD) || (ctl_q == CTL_SUB));
               out_zero     <= alu_zero;
               out_equal    <= alu_equal;
               out_valid    <= 1'b1;
               state        <= S_DONE;
            end

            S_DONE: begin
               // The response registers are written only in IDLE and EXEC, so
               // they hold still while the consumer stalls.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  op_count  <= op_count + 16'd1;
                  state     <= S_IDLE;
               end
            end

            default: begin
               state     <= S_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign alu_control = ctl_q;

endmodule
